// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage RV64M multiply/divide unit.
//   - ALU_* operation codes as seen from decode (M-extension codes live in 5'h10..5'h1C)
//   - MD_* FSM state encodings
//   - md_op_t: per-op control flags decoded once at accept
//   - helpers: is_md() (M-extension op check), decode_op(), sext_w()
package ex_muldiv_pkg;

  // Base ALU codes (only ADD is referenced here, the rest keep the encoding map complete)
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_AND    = 5'h02;
  localparam logic [4:0] ALU_OR     = 5'h03;
  localparam logic [4:0] ALU_XOR    = 5'h04;
  localparam logic [4:0] ALU_SLL    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_SLT    = 5'h08;
  localparam logic [4:0] ALU_SLTU   = 5'h09;

  // M-extension codes
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHU  = 5'h12;
  localparam logic [4:0] ALU_MULHSU = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;
  localparam logic [4:0] ALU_MULW   = 5'h18;
  localparam logic [4:0] ALU_DIVW   = 5'h19;
  localparam logic [4:0] ALU_DIVUW  = 5'h1A;
  localparam logic [4:0] ALU_REMW   = 5'h1B;
  localparam logic [4:0] ALU_REMUW  = 5'h1C;

  // FSM states
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  typedef struct packed {
    logic is_div;    // divide family (DIV*/REM*)
    logic is_rem;    // return remainder instead of quotient
    logic is_w;      // 32-bit word op
    logic signed_a;  // rs1 treated as signed
    logic signed_b;  // rs2 treated as signed
    logic sel_hi;    // return upper half of the product
  } md_op_t;

  function automatic logic is_md(input logic [4:0] op);
    logic r;
    r = 1'b0;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic md_op_t decode_op(input logic [4:0] op);
    md_op_t d;
    d = '0;
    case (op)
      ALU_MUL:    begin d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ALU_MULH:   begin d.signed_a = 1'b1; d.signed_b = 1'b1; d.sel_hi = 1'b1; end
      ALU_MULHU:  begin d.sel_hi = 1'b1; end
      ALU_MULHSU: begin d.signed_a = 1'b1; d.sel_hi = 1'b1; end
      ALU_DIV:    begin d.is_div = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ALU_DIVU:   begin d.is_div = 1'b1; end
      ALU_REM:    begin
        d.is_div = 1'b1; d.is_rem = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1;
      end
      ALU_REMU:   begin d.is_div = 1'b1; d.is_rem = 1'b1; end
      ALU_MULW:   begin d.is_w = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ALU_DIVW:   begin
        d.is_div = 1'b1; d.is_w = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1;
      end
      ALU_DIVUW:  begin d.is_div = 1'b1; d.is_w = 1'b1; end
      ALU_REMW:   begin
        d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1;
      end
      ALU_REMUW:  begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; end
      default:    d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [63:0] sext_w(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: decode/EX <-> multiply/divide unit signal bundle.
//   request : valid, aluop, src_a, src_b, rd, flush   (master drives)
//   status  : ready, busy                             (slave drives)
//   result  : done, result, done_rd                   (slave drives)
interface ex_muldiv_if;
  logic        valid;
  logic [4:0]  aluop;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic [4:0]  rd;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  done_rd;

  modport master (
    output valid, aluop, src_a, src_b, rd, flush,
    input  ready, busy, done, result, done_rd
  );

  modport slave (
    input  valid, aluop, src_a, src_b, rd, flush,
    output ready, busy, done, result, done_rd
  );
endinterface

// File: rtl/ex_muldiv_md_iter_core.sv
// ex_muldiv_md_iter_core: radix-2 multiply/divide iteration engine.
//   clock, reset : clock and synchronous active-low reset
//   load         : capture load_acc/load_opnd/load_div (takes priority over step)
//   load_acc     : initial accumulator ({0, multiplier} or {0, dividend})
//   load_opnd    : multiplicand or divisor
//   load_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   step         : perform one iteration this cycle
//   acc          : accumulator ({hi, lo} product, or {remainder, quotient})
module ex_muldiv_md_iter_core #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [2*XLEN-1:0] load_acc,
  input  logic [XLEN-1:0]   load_opnd,
  input  logic              load_div,
  input  logic              step,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic              div_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right by one.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: trial-subtract the divisor from the left-shifted partial remainder.
    // A set MSB means the subtraction borrowed, so the partial remainder is kept.
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    acc_d    = acc_q;
    if (load) begin
      acc_d = load_acc;
    end else if (step) begin
      if (div_q) begin
        acc_d = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        opnd_q <= load_opnd;
        div_q  <= load_div;
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
//   clock : single clock, all state on posedge
//   reset : synchronous, active-low
//   md    : ex_muldiv_if.slave
//     valid/aluop/src_a/src_b/rd : op from decode, taken when M-extension and ready
//     flush                      : abort any in-flight op, blocks accept
//     ready                      : idle and able to accept
//     busy                       : op in flight (RUN/FIX/DONE); pipeline stalls
//     done/result/done_rd        : one-cycle completion pulse, result and its rd
// A 64-bit op completes N+2 cycles after accept (N=64, or 32 for W ops); divide by zero
// and signed overflow complete in one cycle when FAST_SPEC is set.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter bit          FAST_SPEC = 1'b1
) (
  input logic         clock,
  input logic         reset,
  ex_muldiv_if.slave  md
);

  // Control state
  logic [1:0]      state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [6:0]      cnt_last;
  md_op_t          dec_in, dec_q;
  logic            sign_a_q, sign_b_q;
  logic            special_q;
  logic [XLEN-1:0] spec_q;
  logic [4:0]      rd_q;

  // Output state
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      done_rd_q;

  // Accept-time operand preparation
  logic            accept;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special_in;
  logic [XLEN-1:0] int_min, spec_raw, spec_in;
  logic [2*XLEN-1:0] init_acc;
  logic [XLEN-1:0]   init_opnd;

  // Result fix-up
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

  assign dec_in = decode_op(md.aluop);
  assign accept = md.valid & (state_q == MD_IDLE) & is_md(md.aluop) & ~md.flush;

  always_comb begin
    if (dec_in.is_w) begin
      a_ext = dec_in.signed_a ? sext_w(md.src_a) : {32'b0, md.src_a[31:0]};
      b_ext = dec_in.signed_b ? sext_w(md.src_b) : {32'b0, md.src_b[31:0]};
    end else begin
      a_ext = md.src_a;
      b_ext = md.src_b;
    end
    sign_a = dec_in.signed_a & a_ext[XLEN-1];
    sign_b = dec_in.signed_b & b_ext[XLEN-1];
    mag_a  = sign_a ? (~a_ext + 1'b1) : a_ext;
    mag_b  = sign_b ? (~b_ext + 1'b1) : b_ext;

    int_min    = dec_in.is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero   = dec_in.is_div & (b_ext == '0);
    div_ovf    = dec_in.is_div & dec_in.signed_a & (a_ext == int_min) & (b_ext == '1);
    special_in = div_zero | div_ovf;
    if (div_zero) begin
      spec_raw = dec_in.is_rem ? a_ext : '1;
    end else begin
      spec_raw = dec_in.is_rem ? '0 : a_ext;
    end
    spec_in = dec_in.is_w ? sext_w(spec_raw) : spec_raw;

    // Multiply: multiplier in the low half, multiplicand added at the top.
    // Divide: W dividends are pre-shifted so 32 steps consume all of their bits.
    if (dec_in.is_div) begin
      init_acc  = {{XLEN{1'b0}}, (dec_in.is_w ? {mag_a[31:0], 32'b0} : mag_a)};
      init_opnd = mag_b;
    end else begin
      init_acc  = {{XLEN{1'b0}}, mag_b};
      init_opnd = mag_a;
    end
  end

  ex_muldiv_md_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .load_acc  (init_acc),
    .load_opnd (init_opnd),
    .load_div  (dec_in.is_div),
    .step      (state_q == MD_RUN),
    .acc       (acc)
  );

  always_comb begin
    // After 32 multiply steps the W product sits 32 bits up in the accumulator.
    prod    = dec_q.is_w ? (acc >> 32) : acc;
    prod_s  = (sign_a_q ^ sign_b_q) ? (~prod + 1'b1) : prod;
    quo_s   = (sign_a_q ^ sign_b_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_s   = sign_a_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    if (dec_q.is_div) begin
      fix_raw = dec_q.is_rem ? rem_s : quo_s;
    end else begin
      fix_raw = dec_q.sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
    if (special_q) begin
      fix_res = spec_q;
    end else begin
      fix_res = dec_q.is_w ? sext_w(fix_raw) : fix_raw;
    end
  end

  assign cnt_last = dec_q.is_w ? 7'd31 : 7'd63;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (md.flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            state_d = (FAST_SPEC && special_in) ? MD_DONE : MD_RUN;
            cnt_d   = '0;
          end
        end
        MD_RUN: begin
          if (cnt_q == cnt_last) begin
            state_d = MD_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        MD_FIX:  state_d = MD_DONE;
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      dec_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      spec_q    <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      result_q  <= '0;
      done_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dec_q     <= dec_in;
        sign_a_q  <= sign_a;
        sign_b_q  <= sign_b;
        special_q <= special_in;
        spec_q    <= spec_in;
        rd_q      <= md.rd;
      end
      if (state_q == MD_FIX) begin
        res_q <= fix_res;
      end else if (accept && special_in) begin
        res_q <= spec_in;
      end
      // Commit only an unflushed completion; a flushed DONE leaves the old result visible.
      if (state_q == MD_DONE && !md.flush) begin
        result_q  <= res_q;
        done_rd_q <= rd_q;
      end
    end
  end

  assign md.ready   = (state_q == MD_IDLE);
  assign md.busy    = (state_q != MD_IDLE);
  assign md.done    = (state_q == MD_DONE) & ~md.flush;
  assign md.result  = md.done ? res_q : result_q;
  assign md.done_rd = md.done ? rd_q : done_rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (FAST_SPEC=1).
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  ex_muldiv_if md ();

  ex_muldiv #(
    .XLEN      (64),
    .FAST_SPEC (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .md    (md)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, wait (bounded) for done, check latency/result/rd and that
  // the pulse lasts exactly one cycle with the result held afterwards.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp, input int exp_cyc);
    int cyc;
    md.valid = 1'b1;
    md.aluop = op;
    md.src_a = a;
    md.src_b = b;
    md.rd    = rd;
    @(posedge clock); #1;
    md.valid = 1'b0;
    cyc = 1;
    while (!md.done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, " done"}, 64'(md.done), 64'd1);
    chk({tag, " cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, " result"}, md.result, exp);
    chk({tag, " rd"}, 64'(md.done_rd), 64'(rd));
    @(posedge clock); #1;
    chk({tag, " pulse end"}, 64'(md.done), 64'd0);
    chk({tag, " ready after"}, 64'(md.ready), 64'd1);
    chk({tag, " held"}, md.result, exp);
  endtask

  initial begin
    int cyc;
    int done_seen;
    md.valid = 1'b0;
    md.aluop = ALU_ADD;
    md.src_a = '0;
    md.src_b = '0;
    md.rd    = '0;
    md.flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst ready", 64'(md.ready), 64'd1);
    chk("rst busy", 64'(md.busy), 64'd0);
    chk("rst done", 64'(md.done), 64'd0);
    chk("rst result", md.result, 64'd0);
    chk("rst rd", 64'(md.done_rd), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Main function
    do_op("mul", ALU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    do_op("mulhu", ALU_MULHU, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    do_op("mulhsu", ALU_MULHSU, '1, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("div", ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op("rem", ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("divu", ALU_DIVU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10,
          64'h7FFF_FFFF_FFFF_FFFC, 66);
    do_op("mulw", ALU_MULW, 64'h1_0000, 64'h1_0000, 5'd11, 64'd0, 34);

    // Special cases, single cycle
    do_op("divw ovf", ALU_DIVW, 64'h0000_0000_8000_0000, '1, 5'd12,
          64'hFFFF_FFFF_8000_0000, 1);
    do_op("remw ovf", ALU_REMW, 64'h0000_0000_8000_0000, '1, 5'd13, 64'd0, 1);
    do_op("div by 0", ALU_DIV, 64'd5, 64'd0, 5'd14, '1, 1);
    do_op("remu by 0", ALU_REMU, 64'd5, 64'd0, 5'd15, 64'd5, 1);

    // Non-M op never accepted
    md.valid = 1'b1;
    md.aluop = ALU_ADD;
    repeat (3) begin
      @(posedge clock); #1;
      chk("add ready", 64'(md.ready), 64'd1);
      chk("add busy", 64'(md.busy), 64'd0);
    end

    // flush together with valid in IDLE: no accept
    md.aluop = ALU_DIV;
    md.src_a = 64'd100;
    md.src_b = 64'd7;
    md.flush = 1'b1;
    @(posedge clock); #1;
    md.valid = 1'b0;
    md.flush = 1'b0;
    chk("flush idle busy", 64'(md.busy), 64'd0);

    // flush at cycle 20 of a DIV
    md.valid = 1'b1;
    md.aluop = ALU_DIV;
    md.src_a = 64'd100;
    md.src_b = 64'd7;
    md.rd    = 5'd20;
    @(posedge clock); #1;
    md.valid = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("flush run busy", 64'(md.busy), 64'd1);
    md.flush = 1'b1;
    @(posedge clock); #1;
    md.flush = 1'b0;
    chk("flush ready", 64'(md.ready), 64'd1);
    chk("flush busy", 64'(md.busy), 64'd0);
    done_seen = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (md.done) done_seen++;
    end
    chk("flush no done", 64'(done_seen), 64'd0);
    chk("flush result kept", md.result, 64'd5);

    // flush in DONE suppresses the pulse and keeps the old result
    md.valid = 1'b1;
    md.aluop = ALU_DIV;
    md.src_a = 64'd5;
    md.src_b = 64'd0;
    md.rd    = 5'd21;
    @(posedge clock); #1;
    md.valid = 1'b0;
    chk("fdone busy", 64'(md.busy), 64'd1);
    md.flush = 1'b1;
    #1;
    chk("fdone done", 64'(md.done), 64'd0);
    chk("fdone result", md.result, 64'd5);
    @(posedge clock); #1;
    md.flush = 1'b0;
    chk("fdone ready", 64'(md.ready), 64'd1);
    chk("fdone result after", md.result, 64'd5);
    chk("fdone rd after", 64'(md.done_rd), 64'd15);

    // reset asserted at cycle 10 of a DIV
    md.valid = 1'b1;
    md.aluop = ALU_DIV;
    md.src_a = 64'd100;
    md.src_b = 64'd7;
    md.rd    = 5'd22;
    @(posedge clock); #1;
    md.valid = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("mrst ready", 64'(md.ready), 64'd1);
    chk("mrst busy", 64'(md.busy), 64'd0);
    chk("mrst done", 64'(md.done), 64'd0);
    chk("mrst result", md.result, 64'd0);
    chk("mrst rd", 64'(md.done_rd), 64'd0);
    done_seen = 0;
    repeat (70) begin
      @(posedge clock); #1;
      if (md.done) done_seen++;
    end
    chk("mrst no done", 64'(done_seen), 64'd0);

    // Normal operation after reset
    do_op("div after", ALU_DIV, 64'd100, 64'd7, 5'd23, 64'd14, 66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
